scaled_shift_unit: RTL and testbench
====================================

// Module: scaled_shift_unit
// PURPOSE
//  Parametrised signed scale engine. Loads operands AR and BR, then acts on the sign of AR:
//   AR>0: CR = BR * 2^k (left shift).  AR<0: CR = AR / 2^k (right shift).  AR==0: CR = 0.
//  Shifts iterate one bit per clock under an FSM with a start/busy/done handshake.
//  Adds optional saturation, overflow flag and round-toward-zero. Sits between operand
//  registers and the result bus of the arithmetic datapath.
// PARAMETERS
//  WIDTH       16  operand/result width, signed two's complement (>=4)
//  SHW          4  width of shift-count input; max k = 2^SHW-1
//  SATURATE     1  1: clamp left-shift overflow to max/min; 0: wrap
//  ROUND_ZERO   1  1: right shift truncates toward zero (matches signed '/'); 0: toward -inf
// PORTS
//  clk      in   1       clock, all state on rising edge
//  reset    in   1       asynchronous, active-high reset
//  start    in   1       request; sampled only in IDLE
//  data_ar  in   WIDTH   signed operand A, captured on accepted start
//  data_br  in   WIDTH   signed operand B, captured on accepted start
//  shamt    in   SHW     shift count k, captured on accepted start
//  busy     out  1       high in EVAL and SHIFT
//  done     out  1       one-cycle pulse in DONE; cr/ovf valid from this cycle
//  cr       out  WIDTH   signed result, held until next DONE
//  ovf      out  1       left-shift overflow on last op, held with cr
//  ar_gt_0  out  1       latched AR > 0
//  ar_lt_0  out  1       latched AR < 0
// BEHAVIOUR
//  Reset: state=IDLE; busy, done, ovf, ar_gt_0, ar_lt_0 = 0; cr = 0; internal regs cleared.
//   Reset mid-operation aborts immediately; in-flight result is discarded, never presented.
//  States: IDLE, EVAL, SHIFT, DONE. Edge numbering: E0 = edge sampling start in IDLE.
//  IDLE: start=1 at E0 -> capture AR, BR, cnt=shamt; ar_gt_0/ar_lt_0 updated; -> EVAL.
//   start outside IDLE is ignored (no queueing).
//  EVAL (E1): AR==0 -> res=0, -> DONE. Else mode=LEFT (AR>0, acc=BR) or RIGHT (AR<0, acc=AR);
//   sticky=0, ovf_i=0. cnt==0 -> res=acc, -> DONE; else -> SHIFT.
//  SHIFT: per edge, cnt-=1.
//   LEFT: if acc[W-1]!=acc[W-2], ovf_i=1. acc = acc<<1 (wrap).
//   RIGHT: sticky |= acc[0]; acc = acc>>>1 (sign fill).
//   On the edge where cnt reaches 0 -> DONE, with res:
//   LEFT: ovf_i && SATURATE -> BR<0 ? 1000..0 : 0111..1; else acc.
//   RIGHT: acc + (ROUND_ZERO & sticky), never overflows.
//  DONE: cr<=res, ovf<=ovf_i (LEFT only, else 0) at DONE entry; done=1 one cycle; -> IDLE.
//  Latency: DONE entered at E(1+k), or E1 if k==0 or AR==0; a new start is accepted
//   the cycle after DONE.
//  k may exceed WIDTH-1: LEFT yields 0 (BR==0), else the saturated or wrapped value;
//   RIGHT yields 0 (ROUND_ZERO=1) or -1 (ROUND_ZERO=0).
//  Overflow is sticky within one op; once set, saturation applies even if later bits realign.
//  BR==0 in LEFT never flags ovf. ar_gt_0/ar_lt_0 change only on accepted start.
// TESTING
//  1 reset asserted, random inputs -> busy=done=ovf=0, cr=0, ar flags 0; start ignored while reset=1.
//  2 AR=5, BR=3, k=2 -> done at E3, cr=12, ovf=0, ar_gt_0=1; AR=5, BR=3, k=0 -> cr=3 at E1.
//  3 AR=-7, k=1 -> cr=-3 (ROUND_ZERO=1) / -4 (ROUND_ZERO=0); AR=-1, k=15 -> cr=0 / -1.
//  4 SATURATE=1, AR=1: BR=16'h4000, k=2 -> cr=16'h7FFF, ovf=1; BR=16'hC000, k=1 -> cr=16'h8000,
//    ovf=0; BR=16'hC000, k=2 -> cr=16'h8000, ovf=1. SATURATE=0: BR=16'h4000, k=2 -> cr=0, ovf=1.
//  5 AR=0, BR=16'h1234, k=15 -> done at E1, cr=0, flags 0.
//  6 start pulses while busy -> ignored, cr from first op only; reset mid-SHIFT -> outputs 0,
//    no done pulse; next start completes normally.

Source files
------------

// File: rtl/scaled_shift_unit.sv
// Signed scale engine. The sign of AR selects the operation: AR>0 left-shifts BR by k,
// AR<0 arithmetic-right-shifts AR by k, and AR==0 gives 0. The shift runs one bit per
// clock under a start/busy/done handshake, with optional saturation and round-toward-zero.
module scaled_shift_unit #(
    parameter int unsigned WIDTH      = 16,
    parameter int unsigned SHW        = 4,
    parameter bit          SATURATE   = 1'b1,
    parameter bit          ROUND_ZERO = 1'b1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic signed [WIDTH-1:0] data_ar,
    input  logic signed [WIDTH-1:0] data_br,
    input  logic        [SHW-1:0]   shamt,
    output logic                    busy,
    output logic                    done,
    output logic signed [WIDTH-1:0] cr,
    output logic                    ovf,
    output logic                    ar_gt_0,
    output logic                    ar_lt_0
);

    typedef enum logic [1:0] {StIdle, StEval, StShift, StDone} state_e;

    state_e             state_q;
    logic [WIDTH-1:0]   ar_q;
    logic [WIDTH-1:0]   br_q;
    logic [WIDTH-1:0]   acc_q;
    logic [SHW-1:0]     cnt_q;
    logic               left_q;
    logic               sticky_q;
    logic               ovf_int_q;
    logic               busy_q;
    logic               done_q;
    logic [WIDTH-1:0]   cr_q;
    logic               ovf_q;
    logic               ar_gt_0_q;
    logic               ar_lt_0_q;

    logic [WIDTH-1:0]   acc_left;
    logic [WIDTH-1:0]   acc_right;
    logic               ovf_step;
    logic               sticky_step;
    logic [WIDTH-1:0]   sat_val;
    logic [WIDTH-1:0]   res_left;
    logic [WIDTH-1:0]   res_right;

    // One shift step in either direction, plus the result if this is the final step.
    always_comb begin
        acc_left    = {acc_q[WIDTH-2:0], 1'b0};
        acc_right   = {acc_q[WIDTH-1], acc_q[WIDTH-1:1]};
        // Sign changes on this step if the two top bits disagree before shifting.
        ovf_step    = ovf_int_q | (acc_q[WIDTH-1] ^ acc_q[WIDTH-2]);
        sticky_step = sticky_q | acc_q[0];
        sat_val     = br_q[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        res_left    = (SATURATE && ovf_step) ? sat_val : acc_left;
        // acc is negative here, so adding 1 when bits were lost rounds toward zero.
        res_right   = acc_right + {{(WIDTH-1){1'b0}}, ROUND_ZERO & sticky_step};
    end

    // Control FSM with all datapath registers and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            ar_q      <= '0;
            br_q      <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            left_q    <= 1'b0;
            sticky_q  <= 1'b0;
            ovf_int_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            cr_q      <= '0;
            ovf_q     <= 1'b0;
            ar_gt_0_q <= 1'b0;
            ar_lt_0_q <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    done_q <= 1'b0;
                    if (start) begin
                        ar_q      <= data_ar;
                        br_q      <= data_br;
                        cnt_q     <= shamt;
                        ar_gt_0_q <= ~data_ar[WIDTH-1] & (data_ar != '0);
                        ar_lt_0_q <= data_ar[WIDTH-1];
                        busy_q    <= 1'b1;
                        state_q   <= StEval;
                    end
                end
                StEval: begin
                    left_q    <= ~ar_q[WIDTH-1];
                    acc_q     <= ar_q[WIDTH-1] ? ar_q : br_q;
                    sticky_q  <= 1'b0;
                    ovf_int_q <= 1'b0;
                    if (ar_q == '0 || cnt_q == '0) begin
                        cr_q    <= (ar_q == '0) ? '0 : (ar_q[WIDTH-1] ? ar_q : br_q);
                        ovf_q   <= 1'b0;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= StDone;
                    end else begin
                        state_q <= StShift;
                    end
                end
                StShift: begin
                    cnt_q <= cnt_q - 1'b1;
                    if (left_q) begin
                        acc_q     <= acc_left;
                        ovf_int_q <= ovf_step;
                    end else begin
                        acc_q    <= acc_right;
                        sticky_q <= sticky_step;
                    end
                    if (cnt_q == SHW'(1)) begin
                        cr_q    <= left_q ? res_left : res_right;
                        ovf_q   <= left_q & ovf_step;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= StDone;
                    end
                end
                StDone: begin
                    done_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign cr      = cr_q;
    assign ovf     = ovf_q;
    assign ar_gt_0 = ar_gt_0_q;
    assign ar_lt_0 = ar_lt_0_q;

endmodule

// File: tb/tb_scaled_shift_unit.sv
// Bench for scaled_shift_unit: two instances (saturate+round-to-zero, wrap+floor) share
// inputs and are checked against an exact-arithmetic reference model.
module tb_scaled_shift_unit;

    logic               clk = 1'b0;
    logic               reset;
    logic               start;
    logic signed [15:0] data_ar;
    logic signed [15:0] data_br;
    logic        [3:0]  shamt;

    logic               busy_a, done_a, ovf_a, gt_a, lt_a;
    logic signed [15:0] cr_a;
    logic               busy_b, done_b, ovf_b, gt_b, lt_b;
    logic signed [15:0] cr_b;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    scaled_shift_unit #(.WIDTH(16), .SHW(4), .SATURATE(1'b1), .ROUND_ZERO(1'b1)) u_a (
        .clk(clk), .reset(reset), .start(start), .data_ar(data_ar), .data_br(data_br),
        .shamt(shamt), .busy(busy_a), .done(done_a), .cr(cr_a), .ovf(ovf_a),
        .ar_gt_0(gt_a), .ar_lt_0(lt_a)
    );

    scaled_shift_unit #(.WIDTH(16), .SHW(4), .SATURATE(1'b0), .ROUND_ZERO(1'b0)) u_b (
        .clk(clk), .reset(reset), .start(start), .data_ar(data_ar), .data_br(data_br),
        .shamt(shamt), .busy(busy_b), .done(done_b), .cr(cr_b), .ovf(ovf_b),
        .ar_gt_0(gt_b), .ar_lt_0(lt_b)
    );

    task automatic check(input string tag, input logic signed [63:0] obs,
                         input logic signed [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Exact arithmetic: left = BR*2^k checked against the signed range; right = AR/2^k.
    function automatic void model(input logic signed [15:0] ar, input logic signed [15:0] br,
                                  input int k, input bit sat, input bit rz,
                                  output logic signed [15:0] res, output logic o);
        longint p;
        o = 1'b0;
        if (ar == 0) begin
            res = '0;
        end else if (ar > 0) begin
            p = longint'(br) * (longint'(1) << k);
            if (p > 32767 || p < -32768) begin
                o   = 1'b1;
                res = sat ? ((br < 0) ? 16'sh8000 : 16'sh7fff) : p[15:0];
            end else begin
                res = p[15:0];
            end
        end else begin
            p = longint'(ar);
            if (rz) p = p / (longint'(1) << k);
            else    p = p >>> k;
            res = p[15:0];
        end
    endfunction

    task automatic scramble();
        data_ar = 16'($urandom);
        data_br = 16'($urandom);
        shamt   = 4'($urandom);
    endtask

    // Issue one op from an idle, sampled point and check timing and results on both DUTs.
    task automatic run_op(input logic signed [15:0] ar, input logic signed [15:0] br,
                          input logic [3:0] k);
        logic signed [15:0] ea, eb;
        logic               oa, ob;
        int                 lat, n;
        model(ar, br, int'(k), 1'b1, 1'b1, ea, oa);
        model(ar, br, int'(k), 1'b0, 1'b0, eb, ob);
        lat = (ar == 0 || k == 0) ? 1 : 1 + int'(k);
        data_ar = ar;
        data_br = br;
        shamt   = k;
        start   = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        scramble();
        check("busy after accept", busy_a, 1);
        n = 0;
        while (!done_a && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        check("latency", n, lat);
        check("done b", done_b, 1);
        check("busy at done", busy_a, 0);
        check("cr sat/rz", cr_a, ea);
        check("ovf sat/rz", ovf_a, oa);
        check("cr wrap/floor", cr_b, eb);
        check("ovf wrap/floor", ovf_b, ob);
        check("ar_gt_0", gt_a, (ar > 0) ? 1 : 0);
        check("ar_lt_0", lt_a, (ar < 0) ? 1 : 0);
        @(posedge clk); #1;
        check("done one cycle", done_a, 0);
        check("cr held", cr_a, ea);
    endtask

    initial begin
        int rs;
        logic signed [15:0] ar_r, br_r;

        // Reset with random activity on every input.
        reset = 1'b1;
        start = 1'b0;
        scramble();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            start = 1'($urandom);
            scramble();
        end
        #1;
        check("rst busy", busy_a | busy_b, 0);
        check("rst done", done_a | done_b, 0);
        check("rst ovf", ovf_a | ovf_b, 0);
        check("rst cr a", cr_a, 0);
        check("rst cr b", cr_b, 0);
        check("rst flags", gt_a | lt_a | gt_b | lt_b, 0);
        @(negedge clk);
        start = 1'b0;
        reset = 1'b0;
        @(posedge clk); #1;
        check("idle after reset", busy_a, 0);

        // Directed cases.
        run_op(16'sd5, 16'sd3, 4'd2);
        check("5*3<<2", cr_a, 12);
        run_op(16'sd5, 16'sd3, 4'd0);
        check("k0", cr_a, 3);
        run_op(-16'sd7, 16'sd9, 4'd1);
        check("-7>>1 rz", cr_a, -3);
        check("-7>>1 floor", cr_b, -4);
        run_op(-16'sd1, 16'sd0, 4'd15);
        check("-1>>15 rz", cr_a, 0);
        check("-1>>15 floor", cr_b, -1);
        run_op(16'sd1, 16'sh4000, 4'd2);
        check("sat max", cr_a, 16'sh7fff);
        check("wrap", cr_b, 0);
        run_op(16'sd1, 16'shc000, 4'd1);
        check("no ovf edge", ovf_a, 0);
        run_op(16'sd1, 16'shc000, 4'd2);
        check("sat min", cr_a, -32768);
        run_op(16'sd0, 16'sh1234, 4'd15);
        run_op(16'sd3, 16'sd0, 4'd15);
        run_op(16'sd1, 16'sh0001, 4'd15);
        run_op(-16'sd32768, 16'sd0, 4'd15);

        // Random operations.
        for (int i = 0; i < 40; i++) begin
            rs   = int'($urandom_range(0, 3));
            ar_r = (rs == 0) ? 16'sd0 : 16'($urandom);
            br_r = ($urandom_range(0, 7) == 0) ? 16'sd0 : 16'($urandom);
            run_op(ar_r, br_r, 4'($urandom_range(0, 15)));
        end

        // Start pulses while busy are ignored.
        data_ar = 16'sd1;
        data_br = 16'sd3;
        shamt   = 4'd5;
        start   = 1'b1;
        @(posedge clk); #1;
        data_ar = -16'sd100;
        data_br = 16'sd77;
        shamt   = 4'd1;
        for (int i = 0; i < 6 && !done_a; i++) begin
            @(posedge clk); #1;
        end
        start = 1'b0;
        check("busy-start done", done_a, 1);
        check("busy-start cr", cr_a, 96);
        check("busy-start gt", gt_a, 1);
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            check("no queued op", done_a | busy_a, 0);
        end

        // Reset in the middle of a shift.
        data_ar = 16'sd2;
        data_br = 16'sd5;
        shamt   = 4'd10;
        start   = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("mid busy", busy_a, 1);
        reset = 1'b1;
        #1;
        check("abort busy", busy_a | busy_b, 0);
        check("abort cr", cr_a, 0);
        check("abort flags", gt_a | ovf_a | done_a, 0);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk); #1;
            check("no done after abort", done_a | done_b, 0);
        end
        run_op(16'sd2, 16'sd5, 4'd3);
        check("after abort", cr_a, 40);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
